regfile_read_arb: RTL

REGFILE_READ_ARB -- requirements
Module: regfile_read_arb

---
 rtl/regfile_read_arb_if.sv | 22 ++
 rtl/regfile_read_arb.sv | 86 ++++++++
 2 files changed

// File: rtl/regfile_read_arb_if.sv
// Bundle of request, grant and read-data signals shared between the requesters,
// the register read mux and the read arbiter.
interface regfile_read_arb_if;
  logic [3:0]  req;
  logic [11:0] req_addr;
  logic        hold;
  logic [15:0] mux_out;
  logic [2:0]  mux_sel;
  logic [3:0]  gnt;
  logic [15:0] rdata;
  logic [3:0]  rvalid;

  modport master (
    output req, req_addr, hold, mux_out,
    input  mux_sel, gnt, rdata, rvalid
  );

  modport slave (
    input  req, req_addr, hold, mux_out,
    output mux_sel, gnt, rdata, rvalid
  );
endinterface

// File: rtl/regfile_read_arb.sv
// Round-robin arbiter for four requesters sharing one 8:1 register read mux;
// grant and mux select in one cycle, registered read data the next.
module regfile_read_arb (
  input  logic                clk,
  input  logic                rst,
  regfile_read_arb_if.slave   bus
);

  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  rvalid_q, rvalid_d;
  logic [15:0] rdata_q, rdata_d;
  logic [2:0]  mux_sel_q, mux_sel_d;
  logic [1:0]  ptr_q, ptr_d;

  logic [3:0]  elig_s;
  logic [1:0]  idx_s;
  logic [1:0]  win_s;
  logic        found_s;

  // Winner search starting at the pointer; a requester granted now sits out this edge
  always_comb begin
    elig_s  = bus.req & ~gnt_q;
    found_s = 1'b0;
    win_s   = 2'd0;
    idx_s   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx_s = ptr_q + 2'(k);
      if (!found_s && elig_s[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state for the grant phase and the data phase
  always_comb begin
    gnt_d     = 4'b0000;
    mux_sel_d = mux_sel_q;
    ptr_d     = ptr_q;
    rvalid_d  = gnt_q;
    rdata_d   = rdata_q;
    if (!bus.hold && found_s) begin
      gnt_d     = 4'b0001 << win_s;
      ptr_d     = win_s + 2'd1;
      case (win_s)
        2'd0:    mux_sel_d = bus.req_addr[2:0];
        2'd1:    mux_sel_d = bus.req_addr[5:3];
        2'd2:    mux_sel_d = bus.req_addr[8:6];
        2'd3:    mux_sel_d = bus.req_addr[11:9];
        default: mux_sel_d = 3'd0;
      endcase
    end else begin
      gnt_d = 4'b0000;
    end
    if (gnt_q != 4'b0000) begin
      rdata_d = bus.mux_out;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers; reset discards any in-flight data phase
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= 4'b0000;
      rvalid_q  <= 4'b0000;
      rdata_q   <= 16'h0000;
      mux_sel_q <= 3'd0;
      ptr_q     <= 2'd0;
    end else begin
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      mux_sel_q <= mux_sel_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.mux_sel = mux_sel_q;

endmodule
